// File: rtl/mem_map_pkg.sv
// Purpose: shared memory-map definitions for the data-side memory system.
//   Holds the default peripheral window base, the register offsets inside
//   that window, the TX_STAT bit layout and the decode-select enum used by
//   data_mem_mmio.
// Ports: none (package).
package mem_map_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

  // Word offsets within the peripheral window (byte offset >> 2).
  localparam logic [1:0] OFF_LED     = 2'd0;  // +0x0
  localparam logic [1:0] OFF_CYCLE   = 2'd1;  // +0x4
  localparam logic [1:0] OFF_TX_DATA = 2'd2;  // +0x8
  localparam logic [1:0] OFF_TX_STAT = 2'd3;  // +0xC

  // TX_STAT field positions.
  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LED,
    SEL_CYCLE,
    SEL_TX_DATA,
    SEL_TX_STAT
  } sel_e;

endpackage

// File: rtl/sync_fifo.sv
// Purpose: single-clock FIFO with registered storage (no fall-through).
//   A push while full is accepted only when a pop happens in the same cycle;
//   in that case the head advances and the new entry lands at the tail with
//   the count unchanged. Pops on an empty FIFO are ignored.
// Ports:
//   clk, reset        clock, synchronous active-high reset (pointers/count)
//   i_push, i_wdata   push request and data
//   i_pop             pop request (head consumed at the clock edge)
//   o_rdata           current head entry (don't-care while empty)
//   o_full, o_empty   status flags
//   o_count           number of stored entries (0..DEPTH)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_pop  = i_pop & ~o_empty;
  // When full, wr_ptr == rd_ptr: the new byte overwrites the slot being
  // popped this edge, which is safe because the pop used the pre-edge value.
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push && !reset) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/data_mem_mmio.sv
// Purpose: data-side memory for a single-cycle core. Word RAM at the bottom
//   of the address space plus a peripheral window at MMIO_BASE holding an
//   LED register, a free-running cycle counter and a byte TX FIFO drained by
//   a valid/ready sink. Reads are combinational, writes take effect at the
//   clock edge (read-during-write returns old data).
// Handshake: tx_valid is high whenever the FIFO holds a byte; a byte transfers
//   on a rising edge where tx_valid & tx_ready; tx_data/tx_valid stay stable
//   while tx_valid & !tx_ready.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   we, addr, wdata processor write enable, byte address, write data
//   rdata           combinational read data for addr
//   leds            LED register
//   tx_data         FIFO head byte
//   tx_valid        FIFO non-empty
//   tx_ready        sink accepts head this cycle
module data_mem_mmio
  import mem_map_pkg::*;
#(
  parameter int          RAM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  leds,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int          RAM_AW    = $clog2(RAM_WORDS);
  localparam int          FIFO_CW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0]        r_ram [RAM_WORDS];
  logic [7:0]         r_leds;
  logic [31:0]        r_cycle;
  logic               r_ovf;

  logic [29:0]        w_woff;
  logic               w_mmio_hit;
  sel_e               w_sel;
  logic [RAM_AW-1:0]  w_ram_idx;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [FIFO_CW-1:0] w_count;
  logic [31:0]        w_stat;

  // Word-granular offset from the window base; addr[1:0] never matters.
  assign w_woff     = addr[31:2] - MMIO_BASE[31:2];
  assign w_mmio_hit = (w_woff[29:2] == '0);
  assign w_ram_idx  = addr[RAM_AW+1:2];

  always_comb begin
    w_sel = SEL_NONE;
    if (addr < RAM_BYTES) begin
      w_sel = SEL_RAM;
    end else if (w_mmio_hit) begin
      case (w_woff[1:0])
        OFF_LED:     w_sel = SEL_LED;
        OFF_CYCLE:   w_sel = SEL_CYCLE;
        OFF_TX_DATA: w_sel = SEL_TX_DATA;
        default:     w_sel = SEL_TX_STAT;
      endcase
    end
  end

  assign w_push = we & (w_sel == SEL_TX_DATA);
  assign w_pop  = tx_valid & tx_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (wdata[7:0]),
    .i_pop   (w_pop),
    .o_rdata (tx_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign tx_valid = ~w_empty;
  assign leds     = r_leds;

  always_ff @(posedge clk) begin
    if (we && (w_sel == SEL_RAM) && !reset) r_ram[w_ram_idx] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_leds  <= '0;
      r_cycle <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (we && (w_sel == SEL_LED)) r_leds <= wdata[7:0];

      if (we && (w_sel == SEL_CYCLE)) r_cycle <= '0;
      else                            r_cycle <= r_cycle + 32'd1;

      // A dropped push needs full with no pop this cycle.
      if (we && (w_sel == SEL_TX_STAT))  r_ovf <= 1'b0;
      else if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  always_comb begin
    w_stat                                 = '0;
    w_stat[STAT_FULL_BIT]                  = w_full;
    w_stat[STAT_EMPTY_BIT]                 = w_empty;
    w_stat[STAT_OVF_BIT]                   = r_ovf;
    w_stat[STAT_COUNT_LSB +: FIFO_CW]      = w_count;
  end

  always_comb begin
    rdata = '0;
    case (w_sel)
      SEL_RAM:     rdata = r_ram[w_ram_idx];
      SEL_LED:     rdata = {24'b0, r_leds};
      SEL_CYCLE:   rdata = r_cycle;
      SEL_TX_STAT: rdata = w_stat;
      default:     rdata = '0;
    endcase
  end

endmodule
